// File: rtl/requant_pkg.sv
// Shared definitions for the requantization sequencer: default widths,
// FSM state encoding and the FIFO sizing rule.
package requant_pkg;

  localparam int DEF_WIDTH_DATA_ADD = 32;
  localparam int DEF_CH_NUM_MAX     = 64;
  localparam int DEF_PIPE_LAT       = 2;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int RES_W              = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // The result FIFO must absorb every beat already committed to the shift
  // unit plus one in the issue register and one being popped.
  function automatic bit depth_ok(input int depth, input int lat);
    return depth >= lat + 2;
  endfunction

endpackage

// File: rtl/requant_out_fifo.sv
// Synchronous result FIFO with occupancy count. Output reads as zero while
// empty so the port is clean after reset without clearing the storage.
module requant_out_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/requant_sched.sv
// Requantization sequencer: feeds accumulator beats to a fixed-latency
// external shift/round unit with a per-channel shift amount, and recaptures
// the results into a FIFO so the consumer may stall. Credits bound the
// number of beats in flight so the FIFO cannot overflow.
// Optional feature macro: REQ_PERF_CNT_EN (back-pressure cycle counter on
// stall_cnt); when undefined stall_cnt is constant zero.
module requant_sched
  import requant_pkg::*;
#(
  parameter int WIDTH_DATA_ADD = DEF_WIDTH_DATA_ADD,
  parameter int CH_NUM_MAX     = DEF_CH_NUM_MAX,
  parameter int CH_W           = $clog2(CH_NUM_MAX),
  parameter int PIPE_LAT       = DEF_PIPE_LAT,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [CH_W:0]             cfg_ch_num,
  input  logic [15:0]               cfg_pix_num,
  input  logic                      tbl_wr_en,
  input  logic [CH_W-1:0]           tbl_wr_addr,
  input  logic [WIDTH_DATA_ADD-1:0] tbl_wr_data,
  input  logic                      acc_valid,
  output logic                      acc_ready,
  input  logic [WIDTH_DATA_ADD-1:0] acc_data,
  output logic                      sh_vld,
  output logic [WIDTH_DATA_ADD-1:0] sh_data,
  output logic [WIDTH_DATA_ADD-1:0] sh_amt,
  input  logic [RES_W-1:0]          sh_res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RES_W-1:0]          out_data,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               stall_cnt
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  // An undersized FIFO configuration never accepts beats.
  localparam bit CFG_OK = depth_ok(FIFO_DEPTH, PIPE_LAT);

  state_t                    state;
  logic [CH_W:0]             ch_num_q;
  logic [15:0]               pix_num_q;
  logic [CH_W-1:0]           ch_cnt;
  logic [15:0]               pix_cnt;
  logic [CRED_W-1:0]         credits;
  logic [CRED_W-1:0]         fifo_cnt;
  logic [WIDTH_DATA_ADD-1:0] shift_tbl [CH_NUM_MAX];
  logic [PIPE_LAT-1:0]       sh_vld_p;

  logic start;
  logic accept;
  logic pop;
  logic last_ch;
  logic last_pix;
  logic res_push;

  assign start     = (state == ST_IDLE) && cfg_start;
  assign acc_ready = CFG_OK && (state == ST_RUN) && (credits < CRED_W'(FIFO_DEPTH));
  assign accept    = acc_valid && acc_ready;
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign last_ch   = ({1'b0, ch_cnt} == ch_num_q - 1'b1);
  assign last_pix  = (pix_cnt == pix_num_q - 16'd1);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign res_push  = sh_vld_p[PIPE_LAT-1];

  // Shift table: writable only while idle, survives reset.
  always_ff @(posedge clk) begin
    if (tbl_wr_en && (state == ST_IDLE)) shift_tbl[tbl_wr_addr] <= tbl_wr_data;
  end

  // Frame FSM with channel/pixel position tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ch_num_q  <= '0;
      pix_num_q <= '0;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ch_num_q  <= cfg_ch_num;
            pix_num_q <= cfg_pix_num;
            ch_cnt    <= '0;
            pix_cnt   <= '0;
            state     <= ((cfg_ch_num == '0) || (cfg_pix_num == '0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (last_ch) begin
              ch_cnt  <= '0;
              pix_cnt <= pix_cnt + 16'd1;
              if (last_pix) state <= ST_DRAIN;
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (credits == '0) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Credits: beats accepted but not yet delivered downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // ---- stage p1: issue register towards the shift unit ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_vld  <= 1'b0;
      sh_data <= '0;
      sh_amt  <= '0;
    end else begin
      sh_vld <= accept;
      if (accept) begin
        sh_data <= acc_data;
        sh_amt  <= shift_tbl[ch_cnt];
      end
    end
  end

  // ---- stages p2..p(1+PIPE_LAT): valid shadow of the shift-unit pipeline ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_vld_p <= '0;
    end else begin
      sh_vld_p[0] <= sh_vld;
      for (int i = 1; i < PIPE_LAT; i++) sh_vld_p[i] <= sh_vld_p[i-1];
    end
  end

  requant_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (RES_W)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .din   (sh_res),
    .pop   (pop),
    .dout  (out_data),
    .count (fifo_cnt)
  );

`ifdef REQ_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_q;

  // Downstream back-pressure cycles, restarted by each accepted frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready) begin
      stall_q <= sat_inc32(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_requant_sched.sv
// Self-checking bench for requant_sched: emulates the fixed-latency shift
// unit and compares every cycle against a transaction-level model (beat
// counts, outstanding results with arrival times, frame on/off).
module tb_requant_sched;

  localparam int W     = 32;
  localparam int CHW   = 6;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic [CHW:0]  cfg_ch_num = '0;
  logic [15:0]   cfg_pix_num = '0;
  logic          tbl_wr_en = 1'b0;
  logic [CHW-1:0] tbl_wr_addr = '0;
  logic [W-1:0]  tbl_wr_data = '0;
  logic          acc_valid = 1'b0;
  logic          acc_ready;
  logic [W-1:0]  acc_data = '0;
  logic          sh_vld;
  logic [W-1:0]  sh_data;
  logic [W-1:0]  sh_amt;
  logic [15:0]   sh_res;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_data;
  logic          busy;
  logic          done;
  logic [31:0]   stall_cnt;

  always #5 clk = ~clk;

  requant_sched dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ch_num(cfg_ch_num),
    .cfg_pix_num(cfg_pix_num), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .sh_vld(sh_vld), .sh_data(sh_data), .sh_amt(sh_amt),
    .sh_res(sh_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  // Shift-unit stand-in: any deterministic function works for checking.
  function automatic logic [15:0] su_f(input logic [31:0] d, input logic [31:0] a);
    logic [31:0] s;
    s = d >> a[4:0];
    return s[15:0] ^ a[15:0];
  endfunction

  logic [15:0] su_pipe [LAT];
  always @(posedge clk) begin
    su_pipe[0] <= sh_vld ? su_f(sh_data, sh_amt) : 16'($urandom);
    for (int i = 1; i < LAT; i++) su_pipe[i] <= su_pipe[i-1];
  end
  assign sh_res = su_pipe[LAT-1];

  // Reference model state
  logic [31:0] tbl_m [64];
  int          cyc = 0;
  bit          frame_on;
  int          total, n_acc, n_pop, done_at, ch_m, stall_m;
  bit          prev_acc;
  logic [31:0] prev_data, prev_amt;
  int          q_when[$];
  logic [15:0] q_val[$];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          acc_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    frame_on = 0; total = 0; n_acc = 0; n_pop = 0; done_at = -1; ch_m = 1;
    stall_m = 0; prev_acc = 0; prev_data = '0; prev_amt = '0;
    q_when.delete(); q_val.delete();
  endtask

  // Compare DUT outputs with the model for the current cycle, then advance
  // the model by what happens at the coming clock edge.
  task automatic sample();
    bit e_busy, e_done, e_ready, e_valid, acc_now, pop_now, start_now;
    logic [15:0] e_out;
    if (rst) clear_model();
    e_busy  = frame_on;
    e_done  = (cyc == done_at);
    e_ready = frame_on && (n_acc < total) && ((n_acc - n_pop) < DEPTH);
    e_valid = (q_when.size() > 0) && (q_when[0] <= cyc);
    e_out   = e_valid ? q_val[0] : 16'h0;
    if (done) done_seen++;
    if (acc_valid && acc_ready) acc_seen++;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("acc_ready", 32'(acc_ready), 32'(e_ready));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("sh_vld", 32'(sh_vld), 32'(prev_acc));
    if (prev_acc) begin
      chk("sh_data", sh_data, prev_data);
      chk("sh_amt", sh_amt, prev_amt);
    end
    if (e_valid) chk("out_data", 32'(out_data), 32'(e_out));
    if (rst) begin
      chk("rst_sh_data", sh_data, 32'h0);
      chk("rst_sh_amt", sh_amt, 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
    end
`ifdef REQ_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(stall_m));
`else
    chk("stall_cnt", stall_cnt, 32'h0);
`endif
    if (rst) return;
    acc_now   = acc_valid && e_ready;
    pop_now   = e_valid && out_ready;
    start_now = cfg_start && !e_busy;
    prev_acc  = acc_now;
    if (acc_now) begin
      prev_data = acc_data;
      prev_amt  = tbl_m[n_acc % ch_m];
      q_when.push_back(cyc + 1 + 1 + LAT);
      q_val.push_back(su_f(acc_data, prev_amt));
      n_acc++;
    end
    if (pop_now) begin
      void'(q_when.pop_front());
      void'(q_val.pop_front());
      n_pop++;
      if (n_pop == total) done_at = cyc + 2;
    end
    if (e_done) frame_on = 0;
    if (start_now) begin
      ch_m     = int'(cfg_ch_num);
      total    = int'(cfg_ch_num) * int'(cfg_pix_num);
      n_acc    = 0;
      n_pop    = 0;
      frame_on = 1;
      done_at  = (total == 0) ? cyc + 1 : -1;
      stall_m  = 0;
    end else if (e_valid && !out_ready) begin
      stall_m++;
    end
    if (tbl_wr_en && !e_busy) tbl_m[tbl_wr_addr] = tbl_wr_data;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic write_tbl(input int addr, input logic [31:0] data);
    tbl_wr_en = 1'b1; tbl_wr_addr = CHW'(addr); tbl_wr_data = data;
    tick();
    tbl_wr_en = 1'b0;
  endtask

  task automatic start_frame(input int ch, input int pix);
    cfg_ch_num = (CHW+1)'(ch); cfg_pix_num = 16'(pix); cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Random traffic until the model frame ends or the budget expires.
  task automatic run_frame(input int pv, input int pr, input int budget);
    for (int i = 0; i < budget && frame_on; i++) begin
      acc_valid   = ($urandom_range(0, 99) < pv);
      acc_data    = $urandom;
      out_ready   = ($urandom_range(0, 99) < pr);
      tbl_wr_en   = ($urandom_range(0, 9) == 0);
      tbl_wr_addr = CHW'($urandom);
      tbl_wr_data = $urandom;
      cfg_start   = ($urandom_range(0, 9) == 0);
      cfg_ch_num  = (CHW+1)'($urandom_range(0, 8));
      cfg_pix_num = 16'($urandom_range(0, 3));
      tick();
    end
    acc_valid = 1'b0; tbl_wr_en = 1'b0; cfg_start = 1'b0;
    chk("frame_timeout", 32'(frame_on), 32'h0);
  endtask

  initial begin
    logic [31:0] amts[$];
    logic [31:0] exp_amts [8];
    int ch, pix;
    clear_model();
    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: table {0,1,4,31}, 4 ch x 2 pix, constant data, no back-pressure
    write_tbl(0, 0); write_tbl(1, 1); write_tbl(2, 4); write_tbl(3, 31);
    exp_amts = '{0, 1, 4, 31, 0, 1, 4, 31};
    done_seen = 0;
    start_frame(4, 2);
    acc_valid = 1'b1; acc_data = 32'h0000_0100; out_ready = 1'b1;
    for (int i = 0; i < 60 && frame_on; i++) begin
      tick();
      if (sh_vld) amts.push_back(sh_amt);
    end
    acc_valid = 1'b0;
    chk("t1_frame_end", 32'(frame_on), 32'h0);
    chk("t1_amt_count", 32'(amts.size()), 32'd8);
    for (int i = 0; i < 8 && i < amts.size(); i++) chk("t1_amt_seq", amts[i], exp_amts[i]);
    chk("t1_done_pulses", 32'(done_seen), 32'd1);

    // 2: single-beat latency
    start_frame(1, 1);
    chk("t2_ready", 32'(acc_ready), 32'h1);
    acc_valid = 1'b1; acc_data = 32'h1234_5678;
    tick();
    acc_valid = 1'b0;
    chk("t2_sh_vld_t1", 32'(sh_vld), 32'h1);
    chk("t2_out_valid_t1", 32'(out_valid), 32'h0);
    tick(); tick();
    chk("t2_out_valid_t3", 32'(out_valid), 32'h0);
    tick();
    chk("t2_out_valid_t4", 32'(out_valid), 32'h1);
    run_frame(0, 100, 20);

    // 3: downstream stalled for a whole frame
    acc_seen = 0;
    start_frame(3, 3);
    acc_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      acc_data = $urandom;
      tick();
    end
    chk("t3_accepts", 32'(acc_seen), 32'd4);
    chk("t3_ready_low", 32'(acc_ready), 32'h0);
    run_frame(100, 100, 100);

    // 4: zero-pixel frame
    start_frame(5, 0);
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_sh_vld", 32'(sh_vld), 32'h0);
    tick();
    chk("t4_busy_after", 32'(busy), 32'h0);
    chk("t4_done_after", 32'(done), 32'h0);

    // 5: reset with beats in flight, then a frame with the kept table
    start_frame(4, 3);
    acc_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc_data = $urandom;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("t5_sh_vld", 32'(sh_vld), 32'h0);
    chk("t5_out_valid", 32'(out_valid), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_acc_ready", 32'(acc_ready), 32'h0);
    tick();
    rst = 1'b0; acc_valid = 1'b0;
    tick(); tick(); tick();
    start_frame(4, 1);
    run_frame(80, 60, 200);

    // 6: back-pressure counter
    start_frame(1, 1);
    acc_valid = 1'b1; out_ready = 1'b0; acc_data = 32'hCAFE_0042;
    tick();
    acc_valid = 1'b0;
    tick(); tick(); tick();
    chk("t6_out_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 10; i++) tick();
`ifdef REQ_PERF_CNT_EN
    chk("t6_stall_10", stall_cnt, 32'd10);
`else
    chk("t6_stall_off", stall_cnt, 32'd0);
`endif
    out_ready = 1'b1;
    run_frame(0, 100, 20);
    start_frame(1, 1);
    chk("t6_stall_clear", stall_cnt, 32'd0);
    run_frame(100, 100, 30);

    // Randomized frames with random tables and traffic
    for (int f = 0; f < 6; f++) begin
      ch  = $urandom_range(1, 8);
      pix = $urandom_range(1, 4);
      for (int a = 0; a < ch; a++) write_tbl(a, $urandom);
      start_frame(ch, pix);
      run_frame($urandom_range(30, 100), $urandom_range(30, 100), 400);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
